// File: rtl/spi_reg_master.sv
// SPI mode-0 initiator for the two-byte register protocol: one frame per write,
// two identical frames per read, with the read byte returned on a response strobe.
module spi_reg_master #(
    parameter int CLK_DIV = 4,
    parameter int GAP_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [5:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic       rsp_write,
    output logic [7:0] rsp_rdata,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic       cs_n
);
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYC - 1);

    state_t      state;
    logic [7:0]  div_cnt;
    logic [3:0]  bit_cnt;
    logic        frame2_pend;
    logic [1:0]  miso_sync;
    logic        op_write;
    logic [5:0]  op_addr;
    logic [7:0]  op_wdata;
    logic [14:0] tx_sr;
    logic [15:0] rx_sr;
    logic [15:0] new_word;
    logic        accept;
    logic        phase_end;
    logic        sample_bit;
    logic        reload_frame;

    function automatic logic [15:0] frame_word(input logic wr, input logic [5:0] addr,
                                               input logic [7:0] wdata);
        return {wr, 1'b0, addr, (wr ? wdata : 8'h00)};
    endfunction

    assign accept       = req_valid && req_ready;
    assign phase_end    = (div_cnt == 8'd0);
    // End of a high phase: miso is sampled and mosi advances on the same edge sclk falls.
    assign sample_bit   = (state == S_SHIFT) && sclk && phase_end;
    assign reload_frame = (state == S_GAP) && phase_end && frame2_pend;
    assign new_word     = frame_word(accept ? req_write : op_write,
                                     accept ? req_addr  : op_addr,
                                     accept ? req_wdata : op_wdata);

    always_ff @(posedge clk) begin
        if (accept) begin
            op_write <= req_write;
            op_addr  <= req_addr;
            op_wdata <= req_wdata;
        end
        if (accept || reload_frame)
            tx_sr <= new_word[14:0];
        else if (sample_bit)
            tx_sr <= {tx_sr[13:0], 1'b0};
        if (sample_bit)
            rx_sr <= {rx_sr[14:0], miso_sync[1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            div_cnt     <= 8'd0;
            bit_cnt     <= 4'd0;
            frame2_pend <= 1'b0;
            miso_sync   <= 2'b00;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_write   <= 1'b0;
            rsp_rdata   <= 8'h00;
            sclk        <= 1'b0;
            mosi        <= 1'b0;
            cs_n        <= 1'b1;
        end else begin
            miso_sync <= {miso_sync[0], miso};
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        req_ready   <= 1'b0;
                        frame2_pend <= !req_write;
                        cs_n        <= 1'b0;
                        sclk        <= 1'b0;
                        mosi        <= new_word[15];
                        div_cnt     <= DIV_LOAD;
                        state       <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (phase_end) begin
                        sclk    <= 1'b1;
                        bit_cnt <= 4'd0;
                        div_cnt <= DIV_LOAD;
                        state   <= S_SHIFT;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                S_SHIFT: begin
                    if (!phase_end) begin
                        div_cnt <= div_cnt - 8'd1;
                    end else if (sclk) begin
                        sclk    <= 1'b0;
                        mosi    <= tx_sr[14];
                        div_cnt <= DIV_LOAD;
                    end else if (bit_cnt == 4'd15) begin
                        div_cnt <= DIV_LOAD;
                        state   <= S_HOLD;
                    end else begin
                        sclk    <= 1'b1;
                        bit_cnt <= bit_cnt + 4'd1;
                        div_cnt <= DIV_LOAD;
                    end
                end
                S_HOLD: begin
                    if (phase_end) begin
                        cs_n    <= 1'b1;
                        div_cnt <= GAP_LOAD;
                        state   <= S_GAP;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                S_GAP: begin
                    if (!phase_end) begin
                        div_cnt <= div_cnt - 8'd1;
                    end else if (frame2_pend) begin
                        // Second read frame: the slave returns the byte in its instruction slot.
                        frame2_pend <= 1'b0;
                        cs_n        <= 1'b0;
                        mosi        <= new_word[15];
                        div_cnt     <= DIV_LOAD;
                        state       <= S_SETUP;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_write <= op_write;
                        rsp_rdata <= op_write ? 8'h00 : rx_sr[15:8];
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
